// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one single-port BRAM between two requesters: the host loader
// (port 0) and the placer engine (port 1). One access is accepted per cycle
// and registered onto the BRAM port. Reads return data with a one-cycle
// per-port valid pulse two cycles after acceptance. Round-robin decides
// contention, and a per-port lock keeps ownership across back-to-back
// accesses.
//
// Ports
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   pN_req                 access request from port N (0 = host, 1 = placer)
//   pN_lock                keep ownership after the current access
//   pN_addr/wdata/we       word address, write data, byte enables (0 = read)
//   pN_gnt                 combinational accept
//   pN_rvalid              read data valid for port N (one-cycle pulse)
//   rdata                  shared read data, straight from data_in
//   address/data_out/we    registered BRAM address, write data, byte enables
//   ram_en                 registered BRAM enable
//   data_in                BRAM read data, valid one cycle after ram_en
//   ram_rst                BRAM output-register reset
//   dbg_state_o            {last_served, owner} for observation
//
// Handshake: an access transfers on a rising edge when pN_req && pN_gnt are
// both high. pN_gnt may be high without pN_req (an owner holding its lock);
// that is not a transfer. A requester keeps req/addr/wdata/we stable until
// it samples gnt = 1 and may change them in the following cycle.
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                p0_req,
    input  logic                p0_lock,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_we,
    output logic                p0_gnt,
    output logic                p0_rvalid,

    input  logic                p1_req,
    input  logic                p1_lock,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_we,
    output logic                p1_gnt,
    output logic                p1_rvalid,

    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W/8-1:0] we,
    output logic                ram_en,
    output logic                ram_rst,

    output logic [2:0]          dbg_state_o
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'b00,
        OWNER_P0   = 2'b01,
        OWNER_P1   = 2'b10
    } owner_t;

    owner_t              owner_q;
    logic                last_q;       // port served by the most recent transfer

    logic [ADDR_W-1:0]   address_q;
    logic [DATA_W-1:0]   data_out_q;
    logic [BE_W-1:0]     we_q;
    logic                ram_en_q;
    logic                ram_rst_q;

    // Read tag pipeline: stage 1 follows the BRAM access cycle, the rvalid
    // registers line up with data_in.
    logic                rd_v_q;
    logic                rd_id_q;
    logic                p0_rvalid_q;
    logic                p1_rvalid_q;

    logic                gnt0;
    logic                gnt1;
    logic                xfer0;
    logic                xfer1;
    logic                xfer;
    logic                sel_lock;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_we;
    logic                release_owner;

    // An owner is granted unconditionally, even while it is not requesting;
    // the bubble this creates for the other port is deliberate.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (owner_q)
            OWNER_P0: gnt0 = 1'b1;
            OWNER_P1: gnt1 = 1'b1;
            default: begin
                if (p0_req && p1_req) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = p0_req;
                    gnt1 = p1_req;
                end
            end
        endcase
    end

    assign xfer0 = p0_req & gnt0;
    assign xfer1 = p1_req & gnt1;
    assign xfer  = xfer0 | xfer1;

    assign sel_addr  = xfer1 ? p1_addr  : p0_addr;
    assign sel_wdata = xfer1 ? p1_wdata : p0_wdata;
    assign sel_we    = xfer1 ? p1_we    : p0_we;
    assign sel_lock  = xfer1 ? p1_lock  : p0_lock;

    // An idle owner that drops its lock gives ownership back at this edge;
    // the other port can only be granted in the following cycle.
    assign release_owner = ((owner_q == OWNER_P0) && !p0_lock) ||
                           ((owner_q == OWNER_P1) && !p1_lock);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWNER_NONE;
            last_q      <= 1'b1;
            address_q   <= '0;
            data_out_q  <= '0;
            we_q        <= '0;
            ram_en_q    <= 1'b0;
            ram_rst_q   <= 1'b1;
            rd_v_q      <= 1'b0;
            rd_id_q     <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            // Held high through the first edge after release so the BRAM
            // output register sees one clocked reset.
            ram_rst_q   <= 1'b0;

            rd_v_q      <= xfer && (sel_we == '0);
            rd_id_q     <= xfer1;
            p0_rvalid_q <= rd_v_q && !rd_id_q;
            p1_rvalid_q <= rd_v_q && rd_id_q;

            if (xfer) begin
                address_q  <= sel_addr;
                data_out_q <= sel_wdata;
                we_q       <= sel_we;
                ram_en_q   <= 1'b1;
                last_q     <= xfer1;
                if (sel_lock) begin
                    owner_q <= xfer1 ? OWNER_P1 : OWNER_P0;
                end else begin
                    owner_q <= OWNER_NONE;
                end
            end else begin
                we_q     <= '0;
                ram_en_q <= 1'b0;
                if (release_owner) begin
                    owner_q <= OWNER_NONE;
                end
            end
        end
    end

    assign p0_gnt      = gnt0;
    assign p1_gnt      = gnt1;
    assign p0_rvalid   = p0_rvalid_q;
    assign p1_rvalid   = p1_rvalid_q;
    assign rdata       = data_in;
    assign address     = address_q;
    assign data_out    = data_out_q;
    assign we          = we_q;
    assign ram_en      = ram_en_q;
    assign ram_rst     = ram_rst_q;
    assign dbg_state_o = {last_q, owner_q};

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Drives both ports of bram_port_arbiter, hangs a behavioural BRAM on the
// memory side and checks every cycle against a reference model built from
// the arbitration rules: owner/last-served bookkeeping, a golden memory
// image, and a queue of expected read responses tagged with the cycle they
// are due in.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              p0_req, p0_lock, p0_gnt, p0_rvalid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [BE_W-1:0]   p0_we;
    logic              p1_req, p1_lock, p1_gnt, p1_rvalid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [BE_W-1:0]   p1_we;
    logic [DATA_W-1:0] rdata, data_out, data_in;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   we;
    logic              ram_en, ram_rst;
    logic [2:0]        dbg_state;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_we(p0_we), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_we(p1_we), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .rdata(rdata), .address(address), .data_out(data_out), .data_in(data_in),
        .we(we), .ram_en(ram_en), .ram_rst(ram_rst), .dbg_state_o(dbg_state)
    );

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- behavioural BRAM (read-first) ----------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_rst) begin
            data_in <= '0;
        end else if (ram_en) begin
            data_in <= mem[address];
            mem[address] = merge(mem[address], data_out, we);
        end
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int                due;
        int                port;
        logic [DATA_W-1:0] data;
    } rd_t;

    rd_t               exp_q[$];
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                m_owner;   // -1 none, else owning port
    int                m_last;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [BE_W-1:0]   m_we;
    logic              m_en;
    int                cyc;
    int                checks;
    int                errors;
    logic              g0_last, g1_last;   // transfer happened last cycle
    logic              obs_g0, obs_g1;     // DUT grants sampled last cycle

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_addr  = '0;
        m_dout  = '0;
        m_we    = '0;
        m_en    = 1'b0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs are already driven. Checks grants before the
    // edge, advances the model, then checks registered outputs after it.
    task automatic cycle();
        logic              e0, e1, t0, t1, lk, x0, x1;
        int                k;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, xd;
        logic [BE_W-1:0]   w;
        #1;
        if (m_owner == 0) begin
            e0 = 1'b1; e1 = 1'b0;
        end else if (m_owner == 1) begin
            e0 = 1'b0; e1 = 1'b1;
        end else if (p0_req && p1_req) begin
            e0 = (m_last == 1); e1 = (m_last == 0);
        end else begin
            e0 = p0_req; e1 = p1_req;
        end
        obs_g0 = p0_gnt;
        obs_g1 = p1_gnt;
        check_eq("p0_gnt", {31'd0, p0_gnt}, {31'd0, e0});
        check_eq("p1_gnt", {31'd0, p1_gnt}, {31'd0, e1});
        t0 = p0_req && e0;
        t1 = p1_req && e1;
        g0_last = t0;
        g1_last = t1;
        if (t0 || t1) begin
            k  = t1 ? 1 : 0;
            a  = t1 ? p1_addr  : p0_addr;
            d  = t1 ? p1_wdata : p0_wdata;
            w  = t1 ? p1_we    : p0_we;
            lk = t1 ? p1_lock  : p0_lock;
            m_addr = a; m_dout = d; m_we = w; m_en = 1'b1;
            m_last  = k;
            m_owner = lk ? k : -1;
            if (w == '0) exp_q.push_back('{cyc + 2, k, ref_mem[a]});
            ref_mem[a] = merge(ref_mem[a], d, w);
        end else begin
            m_en = 1'b0;
            m_we = '0;
            if ((m_owner == 0 && !p0_lock) || (m_owner == 1 && !p1_lock)) m_owner = -1;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_eq("address", {19'd0, address}, {19'd0, m_addr});
        check_eq("data_out", data_out, m_dout);
        check_eq("we", {28'd0, we}, {28'd0, m_we});
        check_eq("ram_en", {31'd0, ram_en}, {31'd0, m_en});
        check_eq("ram_rst", {31'd0, ram_rst}, 32'd0);
        x0 = 1'b0; x1 = 1'b0; xd = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].port == 0) x0 = 1'b1; else x1 = 1'b1;
            xd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check_eq("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, x0});
        check_eq("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, x1});
        if (x0 || x1) check_eq("rdata", rdata, xd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0; p1_lock = 1'b0;
        #1;
        check_eq("rst_address", {19'd0, address}, 32'd0);
        check_eq("rst_data_out", data_out, 32'd0);
        check_eq("rst_we", {28'd0, we}, 32'd0);
        check_eq("rst_ram_en", {31'd0, ram_en}, 32'd0);
        check_eq("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        check_eq("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        check_eq("rst_ram_rst", {31'd0, ram_rst}, 32'd1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #2 rst = 1'b0;
        #1 check_eq("ram_rst_after_release", {31'd0, ram_rst}, 32'd1);
        @(posedge clk);
        cyc++;
        #1;
        check_eq("ram_rst_one_clock", {31'd0, ram_rst}, 32'd0);
        check_eq("ram_en_idle", {31'd0, ram_en}, 32'd0);
    endtask

    task automatic new_txn(output logic req, output logic [ADDR_W-1:0] addr,
                           output logic [DATA_W-1:0] wdata, output logic [BE_W-1:0] be);
        req   = ($urandom_range(0, 3) != 0);
        addr  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 7))
                                            : ADDR_W'(13'h1FF8 + 13'($urandom_range(0, 7)));
        wdata = $urandom;
        be    = ($urandom_range(0, 1) == 1) ? '0 : BE_W'($urandom_range(1, 15));
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] wd [0:3];

    initial begin
        rst = 1'b0;
        p0_req = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0; p0_we = '0;
        p1_req = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0; p1_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        checks = 0; errors = 0; cyc = 0;
        g0_last = 1'b0; g1_last = 1'b0; obs_g0 = 1'b0; obs_g1 = 1'b0;
        model_reset();
        #1;
        do_reset();

        // p0 single read of 0x0005
        mem[5] = 32'hA5A5_0005;
        ref_mem[5] = 32'hA5A5_0005;
        p0_req = 1'b1; p0_addr = 13'h0005; p0_we = '0;
        cycle();
        check_eq("t1_address", {19'd0, address}, 32'h5);
        check_eq("t1_ram_en", {31'd0, ram_en}, 32'd1);
        p0_req = 1'b0;
        cycle();
        check_eq("t1_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);
        check_eq("t1_rdata", rdata, 32'hA5A5_0005);
        check_eq("t1_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        cycle();

        // both ports continuously, no lock: strict alternation from p0
        do_reset();
        p0_req = 1'b1; p0_addr = 13'h0010; p0_we = '0;
        p1_req = 1'b1; p1_addr = 13'h0020; p1_we = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("t2_order_p0", {31'd0, obs_g0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("t2_ram_en", {31'd0, ram_en}, 32'd1);
            if (g0_last) p0_addr = ADDR_W'($urandom_range(0, 15));
            if (g1_last) p1_addr = ADDR_W'($urandom_range(16, 31));
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) cycle();

        // p1 locks for four writes while p0 keeps requesting
        p0_req = 1'b1; p0_addr = 13'h0040; p0_we = '0; p0_lock = 1'b0;
        cycle();
        p0_addr = 13'h0041;
        p1_req = 1'b1; p1_we = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wd[i]    = $urandom;
            p1_addr  = ADDR_W'(13'h1FF0 + 13'(i));
            p1_wdata = wd[i];
            p1_lock  = (i < 3);
            cycle();
            check_eq("t3_p0_blocked", {31'd0, obs_g0}, 32'd0);
        end
        p1_req = 1'b0; p1_lock = 1'b0;
        cycle();
        check_eq("t3_p0_after_unlock", {31'd0, obs_g0}, 32'd1);
        p0_req = 1'b0;
        p1_we = '0;
        for (int i = 0; i < 4; i++) begin
            p1_req  = 1'b1;
            p1_addr = ADDR_W'(13'h1FF0 + 13'(i));
            cycle();
        end
        p1_req = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 4; i++) check_eq("t3_bram_word", mem[13'h1FF0 + 13'(i)], wd[i]);

        // partial write then read back from the other port
        p0_req = 1'b1; p0_addr = 13'h0100; p0_wdata = 32'hDEAD_BEEF; p0_we = 4'h3;
        cycle();
        p0_req = 1'b0; p0_we = '0;
        p1_req = 1'b1; p1_addr = 13'h0100; p1_we = '0;
        cycle();
        p1_req = 1'b0;
        cycle();
        check_eq("t4_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
        check_eq("t4_rdata", rdata, 32'h0000_BEEF);
        check_eq("t4_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        cycle();

        // reset while a read is in flight
        p0_req = 1'b1; p0_addr = 13'h0005; p0_we = '0;
        cycle();
        do_reset();
        repeat (3) cycle();

        // idle owner holding its lock blocks the other port
        p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 13'h0008; p0_we = '0;
        cycle();
        p0_req = 1'b0;
        p1_req = 1'b1; p1_addr = 13'h0009; p1_we = '0; p1_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t6_p1_blocked", {31'd0, obs_g1}, 32'd0);
            check_eq("t6_bubble", {31'd0, ram_en}, 32'd0);
        end
        p0_lock = 1'b0;
        cycle();
        check_eq("t6_release_cycle", {31'd0, obs_g1}, 32'd0);
        cycle();
        check_eq("t6_p1_granted", {31'd0, obs_g1}, 32'd1);
        p1_req = 1'b0;
        repeat (2) cycle();

        // randomized traffic
        g0_last = 1'b0; g1_last = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                do_reset();
                g0_last = 1'b0; g1_last = 1'b0;
            end
            if (!p0_req || g0_last) new_txn(p0_req, p0_addr, p0_wdata, p0_we);
            if (!p1_req || g1_last) new_txn(p1_req, p1_addr, p1_wdata, p1_we);
            p0_lock = ($urandom_range(0, 3) == 0);
            p1_lock = ($urandom_range(0, 3) == 0);
            cycle();
        end
        p0_req = 1'b0; p1_req = 1'b0; p0_lock = 1'b0; p1_lock = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter that shares the placer's single BRAM port (13-bit word address, 32-bit data, 4 byte-write-enables) between the host loader (port 0) and the placer engine (port 1). It accepts one access per cycle, registers it onto the BRAM port, and returns read data with a per-port valid pulse. Round-robin fairness applies when both ports request. A per-port lock holds ownership across bursts.

## Interface
- ADDR_W, 13, BRAM word-address width
- DATA_W, 32, BRAM data width; byte-enable width is DATA_W/8
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pN_req  in  1  access request, N = 0 (host) or 1 (placer)
- pN_lock  in  1  keep ownership after the current access
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_we  in  DATA_W/8  byte write enables; all zero means read
- pN_gnt  out  1  combinational accept; an access transfers when pN_req && pN_gnt
- pN_rvalid  out  1  read data valid for port N
- rdata  out  DATA_W  shared read data, equal to data_in
- address  out  ADDR_W  BRAM address (registered)
- data_out  out  DATA_W  BRAM write data (registered)
- data_in  in  DATA_W  BRAM read data, valid one cycle after ram_en
- we  out  DATA_W/8  BRAM byte write enables (registered)
- ram_en  out  1  BRAM enable (registered)
- ram_rst  out  1  BRAM output-register reset

## Operation
- State: owner (NONE, P0, P1) and last_served (0/1).
- Arbitration, combinational each cycle:
  - owner = Pk: only port k may be granted; pk_gnt = 1 and the other gnt = 0, even when pk_req = 0.
  - owner = NONE, one port requesting: that port is granted.
  - owner = NONE, both requesting: the port != last_served is granted.
- Transfer (req && gnt) on a clock edge:
  - address, data_out and we load from the granted port; ram_en = 1.
  - last_served = granted port.
  - owner = that port if its lock = 1, else NONE.
- No transfer:
  - ram_en = 0, we = 0; address and data_out hold.
  - If owner = Pk and pk_lock = 0, owner returns to NONE. The release takes effect for the next cycle's arbitration.
- Only reads (we = 0) produce rvalid.
  - A 2-deep port-ID pipeline tags each accepted read.
  - pN_rvalid pulses for one cycle, two cycles after the accepting edge. This is the cycle data_in is valid.
- rdata is a continuous pass-through of data_in.
- Writes produce no response.
- Each access is one BRAM word; there are no bursts beyond repeated single transfers.

## Timing
- Reset values:
  - address, data_out, we = 0; ram_en = 0.
  - p0_rvalid, p1_rvalid = 0.
  - owner = NONE; last_served = 1, so port 0 wins the first contention.
- ram_rst is 1 asynchronously while rst = 1, stays 1 for the first clock after release, then 0.
- Reset mid-operation clears the ID pipeline. Reads in flight never produce rvalid.
- Throughput: one access per cycle sustained, from either port or alternating.
- Latency for an access accepted at edge E:
  - BRAM signals are driven during the cycle after E.
  - rvalid and rdata are valid during the cycle after E+1.
- A requester holds req, addr, wdata and we stable until it samples gnt = 1. It may change them in the following cycle.
- Lock boundary: if owner drops lock and req in the same cycle, the other port can be granted in the next cycle, not the same one.
- Simultaneous events:
  - Owner holding lock with req = 0 blocks the other port; this bubble is intentional.
  - Lock deasserted together with a transfer: that access completes and owner becomes NONE at the same edge.

## Test plan
- Reset, then p0 reads 0x0005 → address = 0x0005, ram_en = 1 in the cycle after accept; p0_rvalid = 1 with rdata = the BRAM contents one cycle later; p1_rvalid stays 0.
- Both ports request continuously with no lock → grants alternate p0, p1, p0, …, starting with p0 after reset; ram_en = 1 every cycle.
- p1 locks for 4 writes to 0x1FF0–0x1FF3 with we = 0xF while p0 requests throughout → p0_gnt = 0 for all 4 cycles; p0 is granted the cycle after p1 deasserts lock; the BRAM holds the 4 words.
- p0 writes 0xDEADBEEF to 0x0100 with we = 0x3, then p1 reads 0x0100 → p1 sees rdata = 0x0000BEEF when the location was zero beforehand; no rvalid is produced for the write.
- Assert rst one cycle after a read is accepted → no rvalid occurs; all outputs return to reset values immediately; ram_rst is high until one clock after release.
- Owner p0 holds lock with req = 0 for 3 cycles while p1 requests → p1_gnt = 0 and ram_en = 0 for those cycles; p1 is granted once p0's lock falls.
